bram_reader: RTL and testbench

Frame-buffer read-out engine for the pcam-5c-zybo video path. On a start request it scans one frame of 8-bit pixels out of a BRAM port in raster order, accounts for the BRAM's one-cycle synchronous read latency, and emits a timed pixel stream with hsync/vsync framing. It is the read-side counterpart of the camera-to-BRAM capture writer and feeds downstream processing or display logic.

---
 rtl/bram_reader.sv | 202 ++++++++++++++++++++
 tb/tb_bram_reader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_reader.sv
// ---------------------------------------------------------------------------
// bram_reader
//   Frame-buffer read-out engine. On a start request it scans one frame of
//   pixels out of a synchronous-read BRAM in raster order and emits a timed
//   pixel stream with hsync/vsync framing. Sideband flags are delayed two
//   cycles so that they line up with the registered BRAM read data.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        single-cycle frame request, only honoured in IDLE
//   abort        synchronous cancel of the frame in progress
//   bram_addr    BRAM read address (linear raster address)
//   bram_en      BRAM read enable
//   bram_rdata   BRAM read data, valid the cycle after bram_addr/bram_en
//   pixel_out    output pixel
//   pixel_valid  pixel_out carries an active pixel
//   hsync_out    high during horizontal blanking
//   vsync_out    high during vertical blanking
//   busy         frame in progress
//   done         one-cycle pulse once the frame has left the pipeline
//
// States
//   state    | meaning
//   ---------+--------------------------------------------------------
//   S_IDLE   | waiting for start
//   S_VBLANK | V_BLANK cycles of vertical blanking before the first line
//   S_ACTIVE | H_ACTIVE cycles reading one line from the BRAM
//   S_HBLANK | H_BLANK cycles of horizontal blanking after each line
//   S_DRAIN  | 2 cycles letting the sideband pipeline empty
// ---------------------------------------------------------------------------
module bram_reader #(
  parameter int H_ACTIVE = 128,
  parameter int V_ACTIVE = 128,
  parameter int H_BLANK  = 16,
  parameter int V_BLANK  = 8,
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_en,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic [DATA_W-1:0] pixel_out,
  output logic              pixel_valid,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              busy,
  output logic              done
);

  localparam int COL_W   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int ROW_W   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  // The single blanking timer must hold V_BLANK-1, H_BLANK-1 and the drain count 1.
  localparam int TMR_LEN = (V_BLANK > H_BLANK) ? ((V_BLANK > 2) ? V_BLANK : 2)
                                               : ((H_BLANK > 2) ? H_BLANK : 2);
  localparam int TMR_W   = $clog2(TMR_LEN);
  localparam int N_PIX   = H_ACTIVE * V_ACTIVE;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_PIX - 1);
  localparam logic [TMR_W-1:0]  TMR_VB    = TMR_W'(V_BLANK - 1);
  localparam logic [TMR_W-1:0]  TMR_HB    = TMR_W'(H_BLANK - 1);
  localparam logic [TMR_W-1:0]  TMR_DR    = TMR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VBLANK = 3'd1,
    S_ACTIVE = 3'd2,
    S_HBLANK = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [TMR_W-1:0]  tmr;
  logic [COL_W-1:0]  col_cnt;
  logic [ROW_W-1:0]  row_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic              abort_hit;
  logic              frame_go;
  logic              vld_int, hs_int, vs_int;
  logic [1:0]        vld_sr, hs_sr, vs_sr;

  assign abort_hit = abort && (state != S_IDLE);
  // abort beats start when both arrive in IDLE
  assign frame_go  = (state == S_IDLE) && start && !abort;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    if (abort_hit) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (frame_go)          state_nxt = S_VBLANK;
        S_VBLANK: if (tmr == '0)         state_nxt = S_ACTIVE;
        S_ACTIVE: if (col_cnt == COL_LAST) state_nxt = S_HBLANK;
        S_HBLANK: if (tmr == '0)         state_nxt = (row_cnt == ROW_LAST) ? S_DRAIN : S_ACTIVE;
        S_DRAIN:  if (tmr == '0)         state_nxt = S_IDLE;
        default:                         state_nxt = S_IDLE;
      endcase
    end
  end

  // output logic
  always_comb begin
    bram_en = 1'b0;
    busy    = 1'b0;
    vld_int = 1'b0;
    hs_int  = 1'b0;
    vs_int  = 1'b0;
    case (state)
      S_VBLANK: begin busy = 1'b1; vs_int = 1'b1; end
      S_ACTIVE: begin busy = 1'b1; vld_int = 1'b1; bram_en = 1'b1; end
      S_HBLANK: begin busy = 1'b1; hs_int = 1'b1; end
      S_DRAIN:  busy = 1'b1;
      default:  ;
    endcase
  end

  assign bram_addr = addr_cnt;

  // Blanking/drain timer: loaded on state entry, terminal count at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (state_nxt != state) begin
      case (state_nxt)
        S_VBLANK: tmr <= TMR_VB;
        S_HBLANK: tmr <= TMR_HB;
        S_DRAIN:  tmr <= TMR_DR;
        default:  tmr <= '0;
      endcase
    end else if (tmr != '0) begin
      tmr <= tmr - TMR_W'(1);
    end
  end

  // Column, row and linear address counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt  <= '0;
      row_cnt  <= '0;
      addr_cnt <= '0;
    end else begin
      if (state == S_IDLE)
        col_cnt <= '0;
      else if (state == S_ACTIVE)
        col_cnt <= (col_cnt == COL_LAST) ? '0 : col_cnt + COL_W'(1);

      if (state == S_IDLE)
        row_cnt <= '0;
      else if (state == S_HBLANK && tmr == '0 && row_cnt != ROW_LAST)
        row_cnt <= row_cnt + ROW_W'(1);

      // Held on the last pixel rather than wrapping, so the BRAM never sees N_PIX.
      if (frame_go)
        addr_cnt <= '0;
      else if (state == S_ACTIVE && addr_cnt != ADDR_LAST)
        addr_cnt <= addr_cnt + ADDR_W'(1);
    end
  end

  // Two-stage sideband delay; stage 0 lines up with bram_rdata, stage 1 with pixel_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr    <= '0;
      hs_sr     <= '0;
      vs_sr     <= '0;
      pixel_out <= '0;
      done      <= 1'b0;
    end else begin
      if (abort_hit) begin
        vld_sr    <= '0;
        hs_sr     <= '0;
        vs_sr     <= '0;
        pixel_out <= '0;
      end else begin
        vld_sr    <= {vld_sr[0], vld_int};
        hs_sr     <= {hs_sr[0], hs_int};
        vs_sr     <= {vs_sr[0], vs_int};
        pixel_out <= vld_sr[0] ? bram_rdata : '0;
      end
      done <= (state == S_DRAIN) && (state_nxt == S_IDLE) && !abort_hit;
    end
  end

  assign pixel_valid = vld_sr[1];
  assign hsync_out   = hs_sr[1];
  assign vsync_out   = vs_sr[1];

endmodule

// File: tb/tb_bram_reader.sv
module tb_bram_reader;

  // small instance (directed timing) and default instance (full frame)
  localparam int HA = 4, VA = 3, HB = 2, VB = 3, AWA = 4;
  localparam int LA = HA + HB;
  localparam int FA = VB + VA * LA;
  localparam int HAD = 128, VAD = 128, HBD = 16, VBD = 8, AWD = 14;
  localparam int LD = HAD + HBD;
  localparam int FD = VBD + VAD * LD;
  localparam int NB = HAD * VAD;

  typedef struct { int c; logic [7:0] d; } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // ---------------- instance A ----------------
  logic           a_start, a_abort, a_en, a_vld, a_hs, a_vs, a_busy, a_done;
  logic [AWA-1:0] a_addr;
  logic [7:0]     a_rdata, a_pix;
  logic [7:0]     mem_a [16];

  bram_reader #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB),
                .ADDR_W(AWA), .DATA_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort),
    .bram_addr(a_addr), .bram_en(a_en), .bram_rdata(a_rdata),
    .pixel_out(a_pix), .pixel_valid(a_vld), .hsync_out(a_hs), .vsync_out(a_vs),
    .busy(a_busy), .done(a_done));

  always @(posedge clk) if (a_en) a_rdata <= mem_a[a_addr];

  // reference model state: frame start cycle, abort cycle, expected pixels
  int   fs = -1;
  int   ab = -1000;
  exp_t q_a[$];
  int   a_en_cnt = 0, a_done_cnt = 0;

  task automatic a_sync();
    if (fs >= 0 && ab >= fs && cyc > ab) begin
      fs = -1;
      q_a.delete();
    end
  endtask

  function automatic bit a_idle();
    return (fs < 0) || ((cyc - fs) >= FA + 3);
  endfunction

  task automatic a_go(input bit st, input bit abt);
    a_sync();
    a_start = st;
    a_abort = abt;
    if (abt) begin
      if (!a_idle() && (cyc - fs) >= 1) ab = cyc;
    end else if (st && a_idle()) begin
      fs = cyc;
      q_a.delete();
      for (int i = 0; i < HA * VA; i++)
        q_a.push_back('{fs + VB + 3 + (i / HA) * LA + (i % HA), mem_a[i]});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_a(input bit st, input bit abt);
    a_go(st, abt);
    step();
    a_start = 1'b0;
    a_abort = 1'b0;
  endtask

  task automatic finish_a();
    while (!a_idle()) cyc_a(1'b0, 1'b0);
    cyc_a(1'b0, 1'b0);
    cyc_a(1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    int  k, j, e_busy, e_done, e_vs, e_hs, e_vld, e_en, e_addr;
    bit  len;
    exp_t e;
    if (rst_n) begin
      a_sync();
      e_busy = 0; e_done = 0; e_vs = 0; e_hs = 0; e_vld = 0; e_en = 0; e_addr = 0;
      if (fs >= 0) begin
        k = cyc - fs;
        if (k >= 1 && k <= FA + 2) e_busy = 1;
        if (k == FA + 3) e_done = 1;
        if (k >= 3 && k <= VB + 2) e_vs = 1;
        if (k >= VB + 3 && k <= VB + 2 + VA * LA) begin
          j = k - VB - 3;
          if (j % LA < HA) e_vld = 1; else e_hs = 1;
        end
        if (k >= VB + 1 && k <= VB + VA * LA) begin
          j = k - VB - 1;
          if (j % LA < HA) begin e_en = 1; e_addr = (j / LA) * HA + j % LA; end
        end
      end
      len = (cyc == ab + 1) || (cyc == ab + 2);
      chk("a_done", 32'(a_done), e_done);
      chk("a_bram_en", 32'(a_en), e_en);
      if (e_en != 0) chk("a_bram_addr", 32'(a_addr), e_addr);
      if (a_en) chk("a_addr_range", (32'(a_addr) < HA * VA) ? 1 : 0, 1);
      chk("a_exclusive", (32'(a_vld) + 32'(a_hs) + 32'(a_vs) <= 1) ? 1 : 0, 1);
      if (!len) begin
        chk("a_busy", 32'(a_busy), e_busy);
        chk("a_vsync", 32'(a_vs), e_vs);
        chk("a_hsync", 32'(a_hs), e_hs);
        chk("a_valid", 32'(a_vld), e_vld);
        if (a_vld) begin
          if (q_a.size() == 0) chk("a_pix_unexpected", 1, 0);
          else begin
            e = q_a.pop_front();
            chk("a_pix_cycle", cyc, e.c);
            chk("a_pix_data", 32'(a_pix), 32'(e.d));
          end
        end
      end
      if (a_en) a_en_cnt++;
      if (a_done) a_done_cnt++;
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_addr"}, 32'(a_addr), 0);
    chk({tag, "_en"}, 32'(a_en), 0);
    chk({tag, "_pix"}, 32'(a_pix), 0);
    chk({tag, "_valid"}, 32'(a_vld), 0);
    chk({tag, "_hsync"}, 32'(a_hs), 0);
    chk({tag, "_vsync"}, 32'(a_vs), 0);
    chk({tag, "_busy"}, 32'(a_busy), 0);
    chk({tag, "_done"}, 32'(a_done), 0);
  endtask

  // ---------------- instance B (default parameters) ----------------
  logic           b_start, b_abort, b_en, b_vld, b_hs, b_vs, b_busy, b_done;
  logic [AWD-1:0] b_addr;
  logic [7:0]     b_rdata, b_pix;
  logic [7:0]     mem_b [NB];
  exp_t           q_b[$];
  int             b_pix_cnt = 0, b_bursts = 0, b_run = 0, b_done_cnt = 0;

  bram_reader u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
    .bram_addr(b_addr), .bram_en(b_en), .bram_rdata(b_rdata),
    .pixel_out(b_pix), .pixel_valid(b_vld), .hsync_out(b_hs), .vsync_out(b_vs),
    .busy(b_busy), .done(b_done));

  always @(posedge clk) if (b_en) b_rdata <= mem_b[b_addr];

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (b_vld) begin
        b_pix_cnt++;
        if (q_b.size() == 0) chk("b_pix_unexpected", 1, 0);
        else begin
          e = q_b.pop_front();
          chk("b_pix_cycle", cyc, e.c);
          chk("b_pix_data", 32'(b_pix), 32'(e.d));
        end
      end
      if (b_hs) b_run++;
      else if (b_run != 0) begin
        chk("b_hsync_len", b_run, HBD);
        b_bursts++;
        b_run = 0;
      end
      if (b_done) b_done_cnt++;
      if (b_vld || b_hs || b_vs)
        chk("b_exclusive", (32'(b_vld) + 32'(b_hs) + 32'(b_vs) == 1) ? 1 : 0, 1);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    #5000000;
    $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, b_s, ak;
    a_start = 1'b0; a_abort = 1'b0; b_start = 1'b0; b_abort = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) mem_a[i] = 8'(i);
    for (int i = 0; i < NB; i++) mem_b[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    #2 rst_n = 1'b1;
    step(); step();

    // single frame, data i at address i
    d0 = a_done_cnt; e0 = a_en_cnt;
    cyc_a(1'b1, 1'b0);
    finish_a();
    chk("t1_en_cycles", a_en_cnt - e0, HA * VA);
    chk("t1_done_count", a_done_cnt - d0, 1);

    // start held 5 cycles plus a mid-frame pulse
    d0 = a_done_cnt;
    repeat (5) cyc_a(1'b1, 1'b0);
    repeat (7) cyc_a(1'b0, 1'b0);
    cyc_a(1'b1, 1'b0);
    finish_a();
    chk("t2_done_count", a_done_cnt - d0, 1);

    // abort in cycle 8, then a full frame
    d0 = a_done_cnt;
    cyc_a(1'b1, 1'b0);
    repeat (7) cyc_a(1'b0, 1'b0);
    cyc_a(1'b0, 1'b1);
    repeat (FA + 6) cyc_a(1'b0, 1'b0);
    chk("t3_abort_no_done", a_done_cnt - d0, 0);
    cyc_a(1'b1, 1'b0);
    finish_a();
    chk("t3_replay_done", a_done_cnt - d0, 1);

    // abort+start together in IDLE, then abort alone in IDLE
    d0 = a_done_cnt;
    cyc_a(1'b1, 1'b1);
    repeat (FA + 6) cyc_a(1'b0, 1'b0);
    chk("t4_no_frame", a_done_cnt - d0, 0);
    cyc_a(1'b0, 1'b1);
    cyc_a(1'b1, 1'b0);
    finish_a();
    chk("t4_frame_after", a_done_cnt - d0, 1);

    // asynchronous reset mid-row
    d0 = a_done_cnt;
    cyc_a(1'b1, 1'b0);
    repeat (7) cyc_a(1'b0, 1'b0);
    #3 rst_n = 1'b0;
    fs = -1; ab = -1000; q_a.delete();
    #1 check_reset("midrst");
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    repeat (FA) cyc_a(1'b0, 1'b0);
    chk("t5_no_done", a_done_cnt - d0, 0);
    cyc_a(1'b1, 1'b0);
    finish_a();
    chk("t5_frame_after", a_done_cnt - d0, 1);

    // randomized frames with random content, stray starts and aborts
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < HA * VA; i++) mem_a[i] = 8'($urandom);
      repeat ($urandom_range(1, 4)) cyc_a(1'b0, 1'b0);
      cyc_a(1'b1, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        ak = $urandom_range(1, FA + 2);
        repeat (ak - 1) cyc_a(($urandom_range(0, 5) == 0), 1'b0);
        cyc_a(1'b0, 1'b1);
        repeat (4) cyc_a(1'b0, 1'b0);
      end else begin
        repeat (10) cyc_a(($urandom_range(0, 3) == 0), 1'b0);
        finish_a();
      end
    end

    // full default-size frame with random content
    b_s = cyc;
    for (int i = 0; i < NB; i++)
      q_b.push_back('{b_s + VBD + 3 + (i / HAD) * LD + (i % HAD), mem_b[i]});
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    repeat (FD + 8) step();
    chk("b_pixel_count", b_pix_cnt, NB);
    chk("b_hsync_bursts", b_bursts, VAD);
    chk("b_done_count", b_done_cnt, 1);
    chk("b_queue_left", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
